// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: one START/address/data/STOP transaction per
// accepted request, reads a fixed burst, writes a single byte.
// Ports: clk, rst_n (async low), start_read/slave_addr/read_write_n/
//   write_data request; read_data, transaction_done, ack_error, busy
//   status; scl_oe/sda_oe open-drain pulls (1 = low); sda_i pad input.
module i2c_byte_master #(
  parameter int CLK_DIV    = 250,
  parameter int READ_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_read,
  input  logic [6:0] slave_addr,
  input  logic       read_write_n,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  output logic       transaction_done,
  output logic       ack_error,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int            CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);
  localparam logic [2:0]    NB = 3'(READ_BYTES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_MACK,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  logic [2:0]    r_bit;
  logic [2:0]    r_left;
  logic [7:0]    r_tx;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rx;
  logic [7:0]    r_rdata;
  logic          r_rw;
  logic          r_ack;
  logic          r_done;
  logic          r_aerr;
  logic          r_busy;
  logic          r_scl_oe;
  logic          r_sda_oe;

  logic w_tc;
  logic w_sample;
  logic w_slot_end;
  logic w_scl_lo;
  logic w_scl;
  logic w_sda;

  assign w_tc       = (r_cnt == TC);
  assign w_sample   = w_tc && (r_phase == 2'd2);
  assign w_slot_end = w_tc && (r_phase == 2'd3);
  assign w_scl_lo   = (r_phase == 2'd0) || (r_phase == 2'd3);

  // Line drive for the current slot/phase; registered below,
  // so the pads follow the phase counter by one clock.
  always_comb begin
    w_scl = 1'b0;
    w_sda = 1'b0;
    unique case (r_state)
      S_IDLE: begin
      end
      S_START: begin
        w_scl = (r_phase == 2'd3);
        w_sda = r_phase[1];
      end
      S_ADDR, S_WDATA: begin
        w_scl = w_scl_lo;
        w_sda = ~r_tx[7];
      end
      S_AACK, S_WACK, S_RDATA: begin
        w_scl = w_scl_lo;
      end
      S_MACK: begin
        // ACK while more bytes remain, NACK ends the burst
        w_scl = w_scl_lo;
        w_sda = (r_left != 3'd1);
      end
      S_STOP: begin
        w_scl = (r_phase == 2'd0);
        w_sda = ~r_phase[1];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_phase  <= 2'd0;
      r_bit    <= 3'd0;
      r_left   <= 3'd0;
      r_tx     <= 8'h00;
      r_wdata  <= 8'h00;
      r_rx     <= 8'h00;
      r_rdata  <= 8'h00;
      r_rw     <= 1'b0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
      r_aerr   <= 1'b0;
      r_busy   <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_aerr   <= 1'b0;
      r_scl_oe <= w_scl;
      r_sda_oe <= w_sda;
      if (r_state == S_IDLE) begin
        r_cnt   <= '0;
        r_phase <= 2'd0;
        if (start_read) begin
          r_tx    <= {slave_addr, read_write_n};
          r_rw    <= read_write_n;
          r_wdata <= write_data;
          r_busy  <= 1'b1;
          r_state <= S_START;
        end
      end else begin
        r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        if (w_tc) r_phase <= r_phase + 2'd1;
        if (w_sample) begin
          r_ack <= sda_i;
          if (r_state == S_RDATA) r_rx <= {r_rx[6:0], sda_i};
        end
        if (w_slot_end) begin
          unique case (r_state)
            S_START: begin
              r_bit   <= 3'd7;
              r_state <= S_ADDR;
            end
            S_ADDR, S_WDATA: begin
              r_tx <= {r_tx[6:0], 1'b0};
              if (r_bit == 3'd0)
                r_state <= (r_state == S_ADDR) ? S_AACK : S_WACK;
              else
                r_bit <= r_bit - 3'd1;
            end
            S_AACK: begin
              r_bit <= 3'd7;
              if (r_ack) begin
                r_aerr  <= 1'b1;
                r_state <= S_STOP;
              end else if (r_rw) begin
                r_left  <= NB;
                r_state <= S_RDATA;
              end else begin
                r_tx    <= r_wdata;
                r_state <= S_WDATA;
              end
            end
            S_WACK: begin
              r_aerr  <= r_ack;
              r_done  <= ~r_ack;
              r_state <= S_STOP;
            end
            S_RDATA: begin
              if (r_bit == 3'd0) r_state <= S_MACK;
              else               r_bit   <= r_bit - 3'd1;
            end
            S_MACK: begin
              r_rdata <= r_rx;
              r_done  <= 1'b1;
              r_left  <= r_left - 3'd1;
              r_bit   <= 3'd7;
              r_state <= (r_left == 3'd1) ? S_STOP : S_RDATA;
            end
            S_STOP: begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign read_data        = r_rdata;
  assign transaction_done = r_done;
  assign ack_error        = r_aerr;
  assign busy             = r_busy;
  assign scl_oe           = r_scl_oe;
  assign sda_oe           = r_sda_oe;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: behavioural I2C slave and bus monitor
// feed observation queues; a scoreboard holds expected results.
module tb_i2c_byte_master;

  localparam int C  = 4;
  localparam int RB = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_read;
  logic [6:0] slave_addr;
  logic       read_write_n;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       transaction_done;
  logic       ack_error;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;

  logic s_drv;
  logic scl_bus;
  logic sda_bus;
  assign scl_bus = ~scl_oe;
  assign sda_bus = ~sda_oe & ~s_drv;
  assign sda_i   = sda_bus;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(C), .READ_BYTES(RB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_read       (start_read),
    .slave_addr       (slave_addr),
    .read_write_n     (read_write_n),
    .write_data       (write_data),
    .read_data        (read_data),
    .transaction_done (transaction_done),
    .ack_error        (ack_error),
    .busy             (busy),
    .scl_oe           (scl_oe),
    .sda_oe           (sda_oe),
    .sda_i            (sda_i)
  );

  logic [7:0] cfg_rd [4];
  logic       cfg_nack;

  logic [7:0] bus_q [$];
  logic [7:0] done_q [$];
  logic       mack_q [$];
  int         hi_q [$];
  int         busy_q [$];

  int         s_bit;
  int         s_byte;
  logic [7:0] s_sh;
  logic       s_rd;
  logic       s_mack;
  logic       p_scl;
  logic       p_sda;
  logic       p_busy;
  logic       hi_flag;
  int         hi_cnt;
  int         bcnt;
  int         n_start;
  int         n_stop;
  int         n_aerr;
  int         n_both;

  function automatic logic slave_drive(int nb, int nbyte);
    logic [7:0] d;
    slave_drive = 1'b0;
    if (nb == 8 && (nbyte == 0 || (!s_rd && nbyte == 1))) begin
      slave_drive = !cfg_nack;
    end else if (nb < 8 && s_rd && !cfg_nack && nbyte >= 1 &&
                 nbyte <= RB && (nbyte == 1 || !s_mack)) begin
      d = cfg_rd[2'(nbyte - 1)];
      slave_drive = !d[3'(7 - nb)];
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      s_drv   <= 1'b0;
      s_bit   <= 8;
      s_byte  <= -1;
      s_rd    <= 1'b0;
      s_mack  <= 1'b0;
      hi_flag <= 1'b0;
      hi_cnt  <= 0;
      p_scl   <= 1'b1;
      p_sda   <= 1'b1;
      p_busy  <= 1'b0;
      bcnt    <= 0;
    end else begin
      p_scl  <= scl_bus;
      p_sda  <= sda_bus;
      p_busy <= busy;
      if (transaction_done) done_q.push_back(read_data);
      if (ack_error) n_aerr <= n_aerr + 1;
      if (transaction_done && ack_error) n_both <= n_both + 1;
      if (busy) begin
        bcnt <= bcnt + 1;
      end else if (p_busy) begin
        busy_q.push_back(bcnt);
        bcnt <= 0;
      end
      if (p_scl && scl_bus && p_sda && !sda_bus) begin
        n_start <= n_start + 1;
        s_bit   <= 8;
        s_byte  <= -1;
        s_rd    <= 1'b0;
        s_mack  <= 1'b0;
        s_drv   <= 1'b0;
        hi_flag <= 1'b0;
      end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
        n_stop  <= n_stop + 1;
        s_drv   <= 1'b0;
        hi_flag <= 1'b0;
      end else if (!p_scl && scl_bus) begin
        hi_flag <= 1'b1;
        hi_cnt  <= 1;
        if (s_bit < 8) begin
          s_sh <= {s_sh[6:0], sda_bus};
          if (s_bit == 7 && (s_byte == 0 || !s_rd))
            bus_q.push_back({s_sh[6:0], sda_bus});
          if (s_bit == 7 && s_byte == 0) s_rd <= sda_bus;
        end else if (s_rd && s_byte >= 1) begin
          mack_q.push_back(sda_bus);
          s_mack <= sda_bus;
        end
      end else if (p_scl && !scl_bus) begin
        if (hi_flag) hi_q.push_back(hi_cnt);
        hi_flag <= 1'b0;
        s_bit   <= (s_bit == 8) ? 0 : s_bit + 1;
        s_byte  <= (s_bit == 8) ? s_byte + 1 : s_byte;
        s_drv   <= slave_drive((s_bit == 8) ? 0 : s_bit + 1,
                               (s_bit == 8) ? s_byte + 1 : s_byte);
      end else if (scl_bus) begin
        hi_cnt <= hi_cnt + 1;
      end
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rd_model;
  logic [7:0] exp_bus [$];
  logic [7:0] exp_rd [$];
  logic       exp_mack [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [6:0] addr, input logic rw,
                         input logic [7:0] wd, input logic nack,
                         input bit immediate, input bit perturb,
                         input int exp_busy);
    int b0, r0, m0, h0, z0, s0, t0, e0, x0, n, nbit, bad;
    logic [31:0] o;
    if (!immediate) @(negedge clk);
    #1;
    b0 = bus_q.size();
    r0 = done_q.size();
    m0 = mack_q.size();
    h0 = hi_q.size();
    z0 = busy_q.size();
    s0 = n_start;
    t0 = n_stop;
    e0 = n_aerr;
    x0 = n_both;
    exp_bus.push_back({addr, rw});
    if (!nack && !rw) begin
      exp_bus.push_back(wd);
      exp_rd.push_back(rd_model);
    end
    if (!nack && rw) begin
      for (int i = 0; i < RB; i++) begin
        exp_rd.push_back(cfg_rd[i]);
        exp_mack.push_back(i == RB - 1);
      end
      rd_model = cfg_rd[RB-1];
    end
    nbit = nack ? 9 : (rw ? 9 * (1 + RB) : 18);
    cfg_nack     = nack;
    slave_addr   = addr;
    read_write_n = rw;
    write_data   = wd;
    start_read   = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    chk("busy_on_accept", 32'(busy), 32'd1);
    if (perturb) begin
      repeat (100) @(negedge clk);
      slave_addr   = ~addr;
      read_write_n = ~rw;
      write_data   = ~wd;
      start_read   = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
    end
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
    #1;
    chk("busy_timeout", 32'(busy), 32'd0);
    o = 'x;
    if (busy_q.size() > z0) o = 32'(busy_q[z0]);
    chk("busy_cycles", o, 32'(exp_busy));
    n = exp_bus.size();
    chk("bus_byte_count", 32'(bus_q.size() - b0), 32'(n));
    for (int k = 0; k < n; k++) begin
      o = 'x;
      if (b0 + k < bus_q.size()) o = 32'(bus_q[b0+k]);
      chk("bus_byte", o, 32'(exp_bus.pop_front()));
    end
    n = exp_rd.size();
    chk("done_count", 32'(done_q.size() - r0), 32'(n));
    for (int k = 0; k < n; k++) begin
      o = 'x;
      if (r0 + k < done_q.size()) o = 32'(done_q[r0+k]);
      chk("done_read_data", o, 32'(exp_rd.pop_front()));
    end
    n = exp_mack.size();
    chk("master_ack_count", 32'(mack_q.size() - m0), 32'(n));
    for (int k = 0; k < n; k++) begin
      o = 'x;
      if (m0 + k < mack_q.size()) o = 32'(mack_q[m0+k]);
      chk("master_ack_bit", o, 32'(exp_mack.pop_front()));
    end
    chk("ack_error_count", 32'(n_aerr - e0), 32'(nack));
    chk("done_with_ack_error", 32'(n_both - x0), 32'd0);
    chk("start_count", 32'(n_start - s0), 32'd1);
    chk("stop_count", 32'(n_stop - t0), 32'd1);
    chk("scl_pulse_count", 32'(hi_q.size() - h0), 32'(nbit));
    bad = 0;
    for (int k = h0; k < hi_q.size(); k++)
      if (hi_q[k] != 2 * C) bad++;
    chk("scl_high_width_bad", 32'(bad), 32'd0);
    chk("read_data_held", 32'(read_data), 32'(rd_model));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start_read   = 1'b0;
    slave_addr   = 7'h00;
    read_write_n = 1'b0;
    write_data   = 8'h00;
    cfg_nack     = 1'b0;
    cfg_rd       = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    rd_model     = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read_data", 32'(read_data), 32'h0);
    chk("rst_done", 32'(transaction_done), 32'h0);
    chk("rst_ack_error", 32'(ack_error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_scl_oe", 32'(scl_oe), 32'h0);
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(7'h40, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 464);
    run_txn(7'h27, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 320);
    run_txn(7'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 176);
    run_txn(7'h40, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 464);
    cfg_rd = '{8'h3C, 8'h81, 8'h00, 8'h00};
    run_txn(7'h12, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 464);

    @(negedge clk);
    slave_addr   = 7'h40;
    read_write_n = 1'b1;
    start_read   = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    repeat (210) @(negedge clk);
    #2;
    chk("pre_reset_scl_low", 32'(scl_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_scl_oe", 32'(scl_oe), 32'h0);
    chk("abort_sda_oe", 32'(sda_oe), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(transaction_done), 32'h0);
    chk("abort_ack_error", 32'(ack_error), 32'h0);
    chk("abort_read_data", 32'(read_data), 32'h0);
    rd_model = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cfg_rd = '{8'h96, 8'h0F, 8'h00, 8'h00};
    run_txn(7'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 464);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
